// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: state and owner encodings
// plus the default RAM geometry.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker. Bit 0 is the CPU side, bit 1 the debug side.
// A lone requester always wins; on a tie the side that did not win last time
// is chosen. Purely combinational so it can be reused for other shared
// resources.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // Tie goes to the side that was not the previous winner.
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single data RAM between the CPU datapath and the debug/loader
// port using a fixed IDLE -> ACC -> RESP access sequence.
//
//   state | meaning
//   IDLE  | bus free; sample requests, capture winner's addr/we/wdata
//   ACC   | RAM strobed (ram_cs=1); read data sampled on exit
//   RESP  | owner gets done; RAM idle
//
// Every output is either a register or a decode of state/owner, so no
// request input reaches an output combinationally.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 u_pick (
    .req    ({dbg_req, cpu_req}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // State and datapath registers; last starts at DBG so the CPU wins the
  // first contention after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Next-state, request capture and read-data sampling.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACC;
          owner_d = pick_winner;
          if (pick_winner == OWN_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ACC: begin
        state_d = RESP;
        last_d  = owner_q;
        if (!we_q) begin
          if (owner_q == OWN_DBG) dbg_rdata_d = ram_rdata;
          else                    cpu_rdata_d = ram_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from state/owner and the captured registers.
  always_comb begin
    ram_cs    = (state_q == ACC);
    ram_we    = (state_q == ACC) && we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    cpu_gnt   = ((state_q == ACC) || (state_q == RESP)) && (owner_q == OWN_CPU);
    dbg_gnt   = ((state_q == ACC) || (state_q == RESP)) && (owner_q == OWN_DBG);
    cpu_done  = (state_q == RESP) && (owner_q == OWN_CPU);
    dbg_done  = (state_q == RESP) && (owner_q == OWN_DBG);
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a transaction-level reference model plus a small
// RAM behind the DUT, a per-cycle compare on the falling edge, and directed
// scenarios with literal expectations.
module tb_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          cpu_gnt, cpu_done, dbg_gnt, dbg_done;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Power-up contents of the RAM; 0xFFF holds 0x5.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a == 12'hFFF) ? 4'h5 : (a[3:0] ^ 4'h6);
  endfunction

  // RAM seen by the DUT.
  bit [DW-1:0] mem [4096];
  bit          mem_wr [4096];
  always @(posedge clock)
    if (ram_cs && ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      mem_wr[ram_addr] <= 1'b1;
    end
  assign ram_rdata = mem_wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction in flight, tracked as a phase count
  // (0 free, 1 strobe, 2 response) with its own copy of RAM contents.
  typedef struct packed {
    logic          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  int            m_phase;
  txn_t          m_cur;
  logic          m_last;
  logic [DW-1:0] m_rd [2];
  bit [DW-1:0]   m_mem [4096];
  bit            m_wr [4096];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_cur   = '0;
      m_last  = 1'b1;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else begin
      if (m_phase == 0) begin
        if (cpu_req || dbg_req) begin
          m_cur.own = (cpu_req && dbg_req) ? !m_last : dbg_req;
          m_cur.we    = m_cur.own ? dbg_we    : cpu_we;
          m_cur.addr  = m_cur.own ? dbg_addr  : cpu_addr;
          m_cur.wdata = m_cur.own ? dbg_wdata : cpu_wdata;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_cur.we) begin
          m_mem[m_cur.addr] = m_cur.wdata;
          m_wr[m_cur.addr]  = 1'b1;
        end else begin
          m_rd[m_cur.own] = m_wr[m_cur.addr] ? m_mem[m_cur.addr] : pat(m_cur.addr);
        end
        m_last  = m_cur.own;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle compare, plus a log of DUT grants and done times.
  logic dut_grants [$];
  int   done_cyc [$];
  logic p_cgnt = 1'b0, p_dgnt = 1'b0;

  always @(negedge clock) begin
    check("ram_cs",    ram_cs,    m_phase == 1);
    check("ram_we",    ram_we,    m_phase == 1 && m_cur.we);
    check("ram_addr",  ram_addr,  m_cur.addr);
    check("ram_wdata", ram_wdata, m_cur.wdata);
    check("cpu_gnt",   cpu_gnt,   m_phase != 0 && m_cur.own == 1'b0);
    check("dbg_gnt",   dbg_gnt,   m_phase != 0 && m_cur.own == 1'b1);
    check("cpu_done",  cpu_done,  m_phase == 2 && m_cur.own == 1'b0);
    check("dbg_done",  dbg_done,  m_phase == 2 && m_cur.own == 1'b1);
    check("cpu_rdata", cpu_rdata, m_rd[0]);
    check("dbg_rdata", dbg_rdata, m_rd[1]);
    if (cpu_gnt && !p_cgnt) dut_grants.push_back(1'b0);
    if (dbg_gnt && !p_dgnt) dut_grants.push_back(1'b1);
    if (cpu_done || dbg_done) done_cyc.push_back(cyc);
    p_cgnt = cpu_gnt;
    p_dgnt = dbg_gnt;
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    step();
    step();
    @(negedge clock);
    check("reset_all_zero",
          {cpu_gnt, cpu_done, dbg_gnt, dbg_done, ram_cs, ram_we, ram_addr, ram_wdata, cpu_rdata, dbg_rdata}, 0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("idle_cs", ram_cs, 0);

    // CPU write alone
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h123; cpu_wdata = 4'hA;
    step();
    cpu_req = 0; cpu_addr = 12'h3C3; cpu_wdata = 4'h1;
    @(negedge clock);
    check("wr_acc", {ram_cs, ram_we, ram_addr, ram_wdata, dbg_gnt}, {1'b1, 1'b1, 12'h123, 4'hA, 1'b0});
    @(negedge clock);
    check("wr_resp", {ram_cs, cpu_done, cpu_gnt, dbg_gnt}, 4'b0110);
    @(negedge clock);
    check("wr_after", {ram_cs, cpu_done, dbg_gnt}, 3'b000);

    // Debug read of 0xFFF
    step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'hFFF;
    step();
    dbg_req = 0;
    @(negedge clock);
    check("rd_acc", {ram_cs, ram_we, ram_addr, cpu_gnt}, {1'b1, 1'b0, 12'hFFF, 1'b0});
    @(negedge clock);
    check("rd_resp", {dbg_done, dbg_rdata}, {1'b1, 4'h5});
    repeat (3) step();
    check("rd_held", dbg_rdata, 4'h5);

    // CPU reads back its earlier write
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123;
    step();
    cpu_req = 0;
    @(negedge clock);
    @(negedge clock);
    check("rd_back", {cpu_done, cpu_rdata}, {1'b1, 4'hA});

    // Contention from reset
    step();
    reset = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h001;
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h002;
    step();
    dut_grants.delete();
    done_cyc.delete();
    reset = 1'b0;
    repeat (14) step();
    cpu_req = 0; dbg_req = 0;
    repeat (4) step();
    check("cont_grant_cnt", dut_grants.size() >= 4, 1);
    if (dut_grants.size() >= 4)
      check("cont_order", {dut_grants[0], dut_grants[1], dut_grants[2], dut_grants[3]}, 4'b0101);
    check("cont_done_cnt", done_cyc.size() >= 4, 1);
    for (int i = 1; i < 4 && i < done_cyc.size(); i++)
      check("cont_spacing", done_cyc[i] - done_cyc[i-1], 3);
    check("cont_rdata", {cpu_rdata, dbg_rdata}, {4'h7, 4'h4});

    // Captured address is immune to input changes during ACC
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    step();
    cpu_addr = 12'h020; cpu_req = 0;
    @(negedge clock);
    check("cap_acc", {ram_cs, ram_addr}, {1'b1, 12'h010});
    repeat (2) step();

    // Reset during a debug read's ACC
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'hFFF;
    step();
    dbg_req = 0;
    @(negedge clock);
    check("rst_acc_pre", {ram_cs, dbg_gnt}, 2'b11);
    #1 reset = 1'b1;
    #1;
    check("rst_acc_now",
          {cpu_gnt, cpu_done, dbg_gnt, dbg_done, ram_cs, ram_we, ram_addr, ram_wdata, cpu_rdata, dbg_rdata}, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_no_done", {dbg_done, dbg_rdata}, 0);
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
